hazard_ctrl: RTL

- Pipeline sequencing unit for the IF and ID front end.
- Generates the write-enables and flush controls for the PC register and the IF/ID pipeline register, plus the bubble request for ID/EX.
- Handles load-use hazards, control redirects (EX-stage branch and ID-stage jump) and instruction-memory wait states with a small FSM.
- Keeps a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - IF/ID front-end sequencing: PC/IF-ID enables, flushes, ID/EX bubble, stall counter
module hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            imem_ready,
  input  logic [REGW-1:0] ifid_rs,
  input  logic [REGW-1:0] ifid_rt,
  input  logic            ifid_use_rt,
  input  logic            idex_memread,
  input  logic [REGW-1:0] idex_rt,
  input  logic            jump_id,
  input  logic            branch_ex,
  output logic            pc_we,
  output logic            ifid_we,
  output logic            ifid_flush,
  output logic            idex_bubble,
  output logic [CNTW-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, IMWAIT, REDIR} state_t;

  state_t state;
  state_t state_nx;
  logic   lu;

  assign lu = idex_memread && (idex_rt != '0) &&
              ((idex_rt == ifid_rs) || (ifid_use_rt && (idex_rt == ifid_rt)));

  always_comb begin
    pc_we       = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    state_nx    = state;
    if (rst_n) begin
      case (state)
        RUN, IMWAIT: begin
          if (branch_ex) begin
            // Taken branch kills both younger instructions regardless of other hazards.
            pc_we       = 1'b1;
            ifid_we     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            state_nx    = imem_ready ? RUN : REDIR;
          end else if ((state == IMWAIT) && !imem_ready) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            state_nx   = IMWAIT;
          end else if (jump_id) begin
            pc_we      = 1'b1;
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            state_nx   = imem_ready ? RUN : REDIR;
          end else if (lu) begin
            idex_bubble = 1'b1;
            state_nx    = RUN;
          end else if (!imem_ready) begin
            ifid_we    = 1'b1;
            ifid_flush = 1'b1;
            state_nx   = IMWAIT;
          end else begin
            pc_we    = 1'b1;
            ifid_we  = 1'b1;
            state_nx = RUN;
          end
        end
        REDIR: begin
          // Redirect target still in flight; the pipe holds only NOPs so jumps are moot.
          ifid_we = 1'b1;
          if (imem_ready) begin
            pc_we    = 1'b1;
            state_nx = RUN;
          end else begin
            ifid_flush = 1'b1;
          end
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      if (!pc_we && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNTW'(1);
    end
  end

endmodule
